// File: rtl/alu_op_sequencer_pkg.sv
// cpu_ctrl_pkg: opcodes, sequencer states and opcode classification helpers.
package cpu_ctrl_pkg;
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_SHR = 4;
  localparam int unsigned OP_SHL = 5;
  localparam int unsigned OP_ROR = 6;
  localparam int unsigned OP_ROL = 7;
  localparam int unsigned OP_MUL = 8;
  localparam int unsigned OP_DIV = 9;
  localparam int unsigned OP_NEG = 10;
  localparam int unsigned OP_NOT = 11;
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;
  function automatic logic is_unary(input int unsigned op);
    return op == OP_NEG || op == OP_NOT;
  endfunction
  function automatic logic is_two_word(input int unsigned op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic logic is_legal_op(input int unsigned op);
    return op <= OP_NOT;
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: start/ready handshake, IR input and datapath control strobes.
interface alu_op_sequencer_if #(parameter int DATA_WIDTH = 32, parameter int NUM_REGS = 16, parameter int OPCODE_W = 5);
  logic start, mem_ready;
  logic [DATA_WIDTH-1:0] ir;
  logic pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in;
  logic [NUM_REGS-1:0] reg_out, reg_in;
  logic [OPCODE_W-1:0] alu_op;
  logic busy, done, illegal;
  modport master(
    output start, mem_ready, ir,
    input pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in,
    input reg_out, reg_in, alu_op, busy, done, illegal
  );
  modport slave(
    input start, mem_ready, ir,
    output pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in,
    output reg_out, reg_in, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_reg_select_decoder.sv
// reg_select_decoder: register field to one-hot select, flagging fields beyond the register file.
module reg_select_decoder #(parameter int NUM_REGS = 16, parameter int SEL_W = $clog2(NUM_REGS)) (
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] onehot,
  output logic                oor
);
  assign onehot = NUM_REGS'(1) << sel;
  assign oor = 32'(sel) >= 32'(NUM_REGS);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: hardwired fetch/execute control sequencer for register-to-register ALU instructions.
module alu_op_sequencer
  import cpu_ctrl_pkg::*;
#(parameter int DATA_WIDTH = 32, parameter int NUM_REGS = 16, parameter int OPCODE_W = 5) (
  input logic clock,
  input logic clear,
  alu_op_sequencer_if.slave ctl
);
  localparam int REG_SEL_W = $clog2(NUM_REGS);
  localparam int RA_LSB = DATA_WIDTH - OPCODE_W - REG_SEL_W;
  state_t state, state_nxt;
  logic [OPCODE_W-1:0] op;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic ra_bad, rb_bad, rc_bad, unary, two_word, bad;
  assign op = ctl.ir[DATA_WIDTH-1 -: OPCODE_W];
  assign ra = ctl.ir[RA_LSB +: REG_SEL_W];
  assign rb = ctl.ir[RA_LSB - REG_SEL_W +: REG_SEL_W];
  assign rc = ctl.ir[RA_LSB - 2*REG_SEL_W +: REG_SEL_W];
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_ra (.sel(ra), .onehot(ra_oh), .oor(ra_bad));
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rb (.sel(rb), .onehot(rb_oh), .oor(rb_bad));
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rc (.sel(rc), .onehot(rc_oh), .oor(rc_bad));
  assign unary = is_unary(32'(op));
  assign two_word = is_two_word(32'(op));
  // Only fields the instruction actually uses can make it illegal: unary ops ignore Rc, HI/LO ops ignore Ra.
  assign bad = !is_legal_op(32'(op)) || rb_bad || (!unary && rc_bad) || (!two_word && ra_bad);
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else state <= state_nxt;
  assign ctl.busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    {ctl.pc_out, ctl.inc_pc, ctl.mar_in, ctl.z_in, ctl.zlow_out, ctl.zhigh_out, ctl.pc_in} = '0;
    {ctl.read, ctl.mdr_in, ctl.mdr_out, ctl.ir_in, ctl.y_in, ctl.hi_in, ctl.lo_in} = '0;
    {ctl.done, ctl.illegal} = '0;
    ctl.reg_out = '0;
    ctl.reg_in = '0;
    ctl.alu_op = '0;
    case (state)
      IDLE: state_nxt = ctl.start ? T0 : IDLE;
      T0: begin
        {ctl.pc_out, ctl.inc_pc, ctl.mar_in, ctl.z_in} = '1;
        state_nxt = T1;
      end
      T1: begin
        {ctl.zlow_out, ctl.pc_in, ctl.read, ctl.mdr_in} = '1;
        state_nxt = ctl.mem_ready ? T2 : T1;
      end
      T2: begin
        {ctl.mdr_out, ctl.ir_in} = '1;
        state_nxt = T3;
      end
      T3: begin
        ctl.illegal = bad;
        ctl.y_in = !bad;
        ctl.reg_out = bad ? '0 : rb_oh;
        state_nxt = bad ? IDLE : T4;
      end
      T4: begin
        ctl.alu_op = op;
        ctl.z_in = 1'b1;
        ctl.reg_out = unary ? rb_oh : rc_oh;
        state_nxt = T5;
      end
      T5: begin
        ctl.zlow_out = 1'b1;
        ctl.lo_in = two_word;
        ctl.reg_in = two_word ? '0 : ra_oh;
        state_nxt = two_word ? T6 : DONE;
      end
      T6: begin
        {ctl.zhigh_out, ctl.hi_in} = '1;
        state_nxt = DONE;
      end
      DONE: begin
        ctl.done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control sequencer for register-to-register ALU instructions in the bus-based CPU datapath. After a `start` request it generates, cycle by cycle, the datapath control strobes for instruction fetch (T0–T2) and execute (T3–T5/T6). It replaces hand-driven control sequences in the datapath benches. It is parametrised in data width, register-file size and opcode width, and it adds the following:
- a memory-wait stall,
- unary and two-word (HI/LO) result modes,
- illegal-instruction detection,
- a start/done handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 32, IR width.
- `NUM_REGS`, 16, general registers R0..R(NUM_REGS-1), 2..32.
- `OPCODE_W`, 5, opcode field width.
- `REG_SEL_W`, derived `$clog2(NUM_REGS)`, register field width (localparam).

Ports:
- `clock` in 1: sole clock, rising edge.
- `clear` in 1: reset, asynchronous, active-low.
- `start` in 1: request one instruction cycle; sampled only in IDLE.
- `mem_ready` in 1: memory read data valid on Mdatain.
- `ir` in DATA_WIDTH: IR contents. Opcode `ir[DW-1 -: OPCODE_W]`, then Ra, Rb and Rc fields of REG_SEL_W each, packed downward.
- `pc_out`, `inc_pc`, `mar_in`, `z_in`, `zlow_out`, `zhigh_out`, `pc_in`, `read`, `mdr_in`, `mdr_out`, `ir_in`, `y_in`, `hi_in`, `lo_in` out 1: datapath strobes.
- `reg_out` out NUM_REGS: one-hot register bus-drive enable.
- `reg_in` out NUM_REGS: one-hot register load enable.
- `alu_op` out OPCODE_W: ALU function; zero outside T4.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, instruction completed.
- `illegal` out 1: one-cycle pulse, instruction aborted.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE. Outputs are a Moore decode of the state register.
- **IDLE**: all strobes 0. `start`=1 → T0.
- **T0**: `pc_out`, `inc_pc`, `mar_in`, `z_in` → T1.
- **T1**: `zlow_out`, `pc_in`, `read`, `mdr_in`.
  - Stays in T1 while `mem_ready`=0.
  - → T2 on `mem_ready`=1.
- **T2**: `mdr_out`, `ir_in` → T3.
- **T3**: decode the opcode.
  - Illegal if the opcode is unsupported, or any used register field is ≥ NUM_REGS. Then pulse `illegal` in T3, assert no strobes, → IDLE.
  - Otherwise `reg_out[Rb]`, `y_in` → T4.
- **T4**: `alu_op`=opcode and `z_in`.
  - Binary ops assert `reg_out[Rc]`.
  - Unary ops (NEG, NOT) assert `reg_out[Rb]`.
  - → T5.
- **T5**: `zlow_out`.
  - Single-word ops assert `reg_in[Ra]` → DONE.
  - MUL/DIV assert `lo_in` → T6.
- **T6**: `zhigh_out`, `hi_in` → DONE.
- **DONE**: `done`=1 → IDLE.
- Supported ops: ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT. Codes are defined in the package.
- `start` outside IDLE is ignored, with no queueing.
- `reg_out` and `reg_in` are never both nonzero in the same cycle; each has at most one bit set.

## Timing
- Reset: state=IDLE and every output 0, immediately on `clear` falling, independent of `clock`. Reset mid-instruction abandons it with no `done` or `illegal`.
- Latency with `mem_ready` held 1, with start sampled at edge k:
  - T0 runs in cycle k+1.
  - Single-word op: `done` in cycle k+7.
  - MUL/DIV: `done` in cycle k+8.
  - Illegal: `illegal` in cycle k+4.
- Each cycle of `mem_ready`=0 in T1 adds one cycle. `read`/`mdr_in`/`pc_in` stay asserted throughout. Z is not reloaded, so PC is unchanged by repeated `pc_in`.
- Back-to-back: `start` high during DONE is ignored. The next instruction starts from IDLE, giving at least one idle cycle between instructions.
- Decode uses `ir` as sampled in T3; `ir` must be stable from the end of T2.

## Structure
- Package `cpu_ctrl_pkg`: opcode localparams, state enum, and the `is_unary` / `is_two_word` / `is_legal_op` functions.
- One sub-module, `reg_select_decoder`: binary field → NUM_REGS one-hot plus an out-of-range flag, used for Ra, Rb and Rc.

## Test plan
- **AND R1,R2,R3** (R2=0x12, R3=0x10), `mem_ready`=1 → strobe sequence T0..T5 exactly as above; R1=0x10; `done` at cycle k+7.
- **MUL R4,R5,R6** (0x00010000 × 0x00010000) → LO=0x00000000, HI=0x00000001; `lo_in` in T5, `hi_in` in T6; `done` at k+8.
- **NEG R1,R2** with R2=1, plus `mem_ready` low for 3 cycles in T1 → T1 lasts 4 cycles; `reg_out[2]` in both T3 and T4; R1=0xFFFFFFFF; `done` at k+10.
- **Opcode 5'b11111**; then NUM_REGS=12 with Rc=13 → `illegal` pulse at k+4, `reg_in`=0 throughout, return to IDLE.
- **`clear` low in T4** → all outputs 0 asynchronously; after release, a `start` runs a full clean instruction.
- **`start` held high continuously** → instructions separated by DONE+IDLE; `busy` low exactly one cycle between them.
